// File: rtl/load_store_unit.sv
// rtl/load_store_unit.sv - RV32I load/store unit with registered data-bus master
// Optional bus watchdog compiled in with LSU_TIMEOUT_EN.
module load_store_unit #(
  parameter int unsigned TIMEOUT_CYCLES = 255
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        req_valid,
  input  logic        req_wen,
  input  logic [2:0]  req_func3,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  output logic        stall_o,
  output logic        rsp_valid,
  output logic [31:0] rsp_rdata,
  output logic        err_misalign,
  output logic        err_timeout,
  output logic        dbus_valid,
  output logic        dbus_wen,
  output logic [31:0] dbus_addr,
  output logic [31:0] dbus_wdata,
  output logic [3:0]  dbus_wstrb,
  input  logic        dbus_ready,
  input  logic [31:0] dbus_rdata
);

  typedef enum logic [1:0] {S_IDLE, S_BUS, S_RESP} state_t;

  state_t      state_q, state_d;
  logic [2:0]  func3_q;
  logic        misalign;
  logic        tmo_hit;
  logic [31:0] st_wdata;
  logic [3:0]  st_wstrb;
  logic [31:0] ld_shift;
  logic [31:0] ld_data;

  always_comb begin
    misalign = 1'b0;
    case (req_func3[1:0])
      2'b00:   misalign = 1'b0;
      2'b01:   misalign = req_addr[0];
      default: misalign = |req_addr[1:0];
    endcase
  end

  always_comb begin
    st_wdata = req_wdata;
    st_wstrb = 4'b1111;
    case (req_func3)
      3'b000: begin
        st_wdata = {4{req_wdata[7:0]}};
        st_wstrb = 4'b0001 << req_addr[1:0];
      end
      3'b001: begin
        st_wdata = {2{req_wdata[15:0]}};
        st_wstrb = req_addr[1] ? 4'b1100 : 4'b0011;
      end
      default: begin
        st_wdata = req_wdata;
        st_wstrb = 4'b1111;
      end
    endcase
  end

  // Load lane selection uses the registered address of the access in flight.
  always_comb begin
    ld_shift = dbus_rdata >> {dbus_addr[1:0], 3'b000};
    ld_data  = dbus_rdata;
    case (func3_q)
      3'b000:  ld_data = {{24{ld_shift[7]}}, ld_shift[7:0]};
      3'b001:  ld_data = {{16{ld_shift[15]}}, ld_shift[15:0]};
      3'b100:  ld_data = {24'd0, ld_shift[7:0]};
      3'b101:  ld_data = {16'd0, ld_shift[15:0]};
      default: ld_data = dbus_rdata;
    endcase
  end

`ifdef LSU_TIMEOUT_EN
  logic [15:0] tmo_cnt_q;

  // Counter is zero outside BUS, so it is naturally cleared on BUS entry.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      tmo_cnt_q <= 16'd0;
    end else if (state_q != S_BUS) begin
      tmo_cnt_q <= 16'd0;
    end else begin
      tmo_cnt_q <= tmo_cnt_q + 16'd1;
    end
  end

  assign tmo_hit = !dbus_ready && (tmo_cnt_q == 16'(TIMEOUT_CYCLES - 1));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      err_timeout <= 1'b0;
    end else if (state_q == S_BUS && tmo_hit) begin
      err_timeout <= 1'b1;
    end else begin
      err_timeout <= 1'b0;
    end
  end
`else
  assign tmo_hit     = 1'b0;
  assign err_timeout = 1'b0;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE: begin
        if (req_valid) begin
          state_d = misalign ? S_RESP : S_BUS;
        end
      end
      S_BUS: begin
        if (dbus_ready || tmo_hit) begin
          state_d = S_RESP;
        end
      end
      S_RESP:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  assign stall_o = req_valid && (state_q != S_RESP);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      dbus_valid   <= 1'b0;
      dbus_wen     <= 1'b0;
      dbus_addr    <= 32'd0;
      dbus_wdata   <= 32'd0;
      dbus_wstrb   <= 4'b0000;
      func3_q      <= 3'd0;
      rsp_valid    <= 1'b0;
      rsp_rdata    <= 32'd0;
      err_misalign <= 1'b0;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (req_valid && !misalign) begin
            dbus_valid <= 1'b1;
            dbus_wen   <= req_wen;
            dbus_addr  <= req_addr;
            dbus_wdata <= st_wdata;
            dbus_wstrb <= req_wen ? st_wstrb : 4'b0000;
            func3_q    <= req_func3;
          end else if (req_valid) begin
            rsp_valid    <= 1'b1;
            err_misalign <= 1'b1;
            rsp_rdata    <= 32'd0;
          end
        end
        S_BUS: begin
          if (dbus_ready) begin
            dbus_valid <= 1'b0;
            rsp_valid  <= 1'b1;
            rsp_rdata  <= dbus_wen ? 32'd0 : ld_data;
          end else if (tmo_hit) begin
            dbus_valid <= 1'b0;
            rsp_valid  <= 1'b1;
            rsp_rdata  <= 32'd0;
          end
        end
        default: begin
          rsp_valid    <= 1'b0;
          rsp_rdata    <= 32'd0;
          err_misalign <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_load_store_unit.sv
// tb/tb_load_store_unit.sv - scoreboard bench for load_store_unit
module tb_load_store_unit;

  localparam int TMO = 4;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        req_valid;
  logic        req_wen;
  logic [2:0]  req_func3;
  logic [31:0] req_addr;
  logic [31:0] req_wdata;
  logic        stall_o;
  logic        rsp_valid;
  logic [31:0] rsp_rdata;
  logic        err_misalign;
  logic        err_timeout;
  logic        dbus_valid;
  logic        dbus_wen;
  logic [31:0] dbus_addr;
  logic [31:0] dbus_wdata;
  logic [3:0]  dbus_wstrb;
  logic        dbus_ready;
  logic [31:0] dbus_rdata;

  load_store_unit #(.TIMEOUT_CYCLES(TMO)) dut (
    .clk(clk), .rst_n(rst_n),
    .req_valid(req_valid), .req_wen(req_wen), .req_func3(req_func3),
    .req_addr(req_addr), .req_wdata(req_wdata),
    .stall_o(stall_o), .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata),
    .err_misalign(err_misalign), .err_timeout(err_timeout),
    .dbus_valid(dbus_valid), .dbus_wen(dbus_wen), .dbus_addr(dbus_addr),
    .dbus_wdata(dbus_wdata), .dbus_wstrb(dbus_wstrb),
    .dbus_ready(dbus_ready), .dbus_rdata(dbus_rdata)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] rdata;
    logic        mis;
    logic        tmo;
    int          lat;
    int          nbus;
    int          t0;
  } rsp_t;

  typedef struct {
    logic [31:0] addr;
    logic        wen;
    logic [31:0] wdata;
    logic [3:0]  wstrb;
  } bus_t;

  rsp_t        rsp_q[$];
  bus_t        bus_q[$];
  int          checks = 0;
  int          errors = 0;
  int          cyc = 0;
  int          slave_delay = 1;
  logic [31:0] slave_rdata = 32'd0;
  int          bus_cnt = 0;
  int          nbus_cnt = 0;
  int          rsp_cnt = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  function automatic logic [31:0] ld_model(input logic [2:0] f3, input logic [31:0] addr,
                                           input logic [31:0] w);
    logic [7:0]  by;
    logic [15:0] hw;
    case (addr[1:0])
      2'd0:    by = w[7:0];
      2'd1:    by = w[15:8];
      2'd2:    by = w[23:16];
      default: by = w[31:24];
    endcase
    hw = addr[1] ? w[31:16] : w[15:0];
    case (f3)
      3'b000:  return {{24{by[7]}}, by};
      3'b001:  return {{16{hw[15]}}, hw};
      3'b100:  return {24'd0, by};
      3'b101:  return {16'd0, hw};
      default: return w;
    endcase
  endfunction

  function automatic logic mis_model(input logic [2:0] f3, input logic [31:0] addr);
    case (f3)
      3'b000, 3'b100: return 1'b0;
      3'b001, 3'b101: return addr[0];
      default:        return addr[1:0] != 2'b00;
    endcase
  endfunction

  always @(posedge clk) cyc <= cyc + 1;

  // Bus slave and response monitor, all sampling on the falling edge.
  always @(negedge clk) begin
    rsp_t e;
    bus_t b;
    if (!rst_n) begin
      bus_cnt = 0;
      nbus_cnt = 0;
      dbus_ready = 1'b0;
    end else begin
      if (dbus_valid) begin
        bus_cnt++;
        nbus_cnt++;
        if (bus_cnt == 1) begin
          if (bus_q.size() == 0) begin
            chk("unexp_bus", 1, 0);
          end else begin
            b = bus_q.pop_front();
            chk("bus_addr", dbus_addr, b.addr);
            chk("bus_wen", 32'(dbus_wen), 32'(b.wen));
            chk("bus_wstrb", 32'(dbus_wstrb), 32'(b.wstrb));
            if (b.wen) chk("bus_wdata", dbus_wdata, b.wdata);
          end
        end
        chk("stall_bus", 32'(stall_o), 32'(req_valid));
        dbus_ready = (bus_cnt == slave_delay);
        dbus_rdata = dbus_ready ? slave_rdata : 32'hDEAD_BEEF;
      end else begin
        bus_cnt = 0;
        dbus_ready = 1'b0;
      end
      if (rsp_valid) begin
        if (rsp_q.size() == 0) begin
          chk("unexp_rsp", 1, 0);
        end else begin
          e = rsp_q.pop_front();
          chk("rsp_rdata", rsp_rdata, e.rdata);
          chk("err_mis", 32'(err_misalign), 32'(e.mis));
          chk("err_tmo", 32'(err_timeout), 32'(e.tmo));
          chk("latency", 32'(cyc - e.t0), 32'(e.lat));
          chk("bus_cycles", 32'(nbus_cnt), 32'(e.nbus));
          chk("stall_resp", 32'(stall_o), 0);
        end
        nbus_cnt = 0;
        rsp_cnt++;
      end
    end
  end

  task automatic do_req(input logic wen, input logic [2:0] f3, input logic [31:0] addr,
                        input logic [31:0] wdata, input logic [31:0] rdata, input int delay);
    rsp_t e;
    bus_t b;
    int   n0;
    @(negedge clk); #1;
    slave_delay = delay;
    slave_rdata = rdata;
    e.t0 = cyc;
    e.mis = mis_model(f3, addr);
    e.tmo = 1'b0;
    if (e.mis) begin
      e.nbus = 0;
      e.lat = 1;
      e.rdata = 32'd0;
    end else begin
`ifdef LSU_TIMEOUT_EN
      e.tmo = (delay == 0) || (delay > TMO);
`endif
      e.nbus = e.tmo ? TMO : delay;
      e.lat = e.nbus + 1;
      e.rdata = (wen || e.tmo) ? 32'd0 : ld_model(f3, addr, rdata);
      b.addr = addr;
      b.wen = wen;
      case (f3)
        3'b000: begin b.wdata = {4{wdata[7:0]}}; b.wstrb = 4'b0001 << addr[1:0]; end
        3'b001: begin b.wdata = {2{wdata[15:0]}}; b.wstrb = addr[1] ? 4'b1100 : 4'b0011; end
        default: begin b.wdata = wdata; b.wstrb = 4'b1111; end
      endcase
      if (!wen) b.wstrb = 4'b0000;
      bus_q.push_back(b);
    end
    rsp_q.push_back(e);
    req_wen = wen;
    req_func3 = f3;
    req_addr = addr;
    req_wdata = wdata;
    req_valid = 1'b1;
    n0 = rsp_cnt;
    for (int i = 0; i < 100 && rsp_cnt == n0; i++) begin
      @(negedge clk); #1;
    end
    if (rsp_cnt == n0) chk("rsp_wait", 0, 1);
    req_valid = 1'b0;
  endtask

  initial begin
    bus_t b;
    rst_n = 1'b0;
    req_valid = 1'b0;
    req_wen = 1'b0;
    req_func3 = 3'd0;
    req_addr = 32'd0;
    req_wdata = 32'd0;
    dbus_ready = 1'b0;
    dbus_rdata = 32'd0;
    repeat (3) @(negedge clk);
    chk("rst_dbus_valid", 32'(dbus_valid), 0);
    chk("rst_dbus_wstrb", 32'(dbus_wstrb), 0);
    chk("rst_dbus_addr", dbus_addr, 0);
    chk("rst_rsp_valid", 32'(rsp_valid), 0);
    chk("rst_rsp_rdata", rsp_rdata, 0);
    #1 rst_n = 1'b1;

    do_req(1'b0, 3'b000, 32'h0000_0103, 32'd0, 32'h80FF_FFFF, 1);
    do_req(1'b1, 3'b001, 32'h0000_0202, 32'h0000_ABCD, 32'd0, 1);
    do_req(1'b0, 3'b010, 32'h0000_0101, 32'd0, 32'h1111_1111, 1);
    do_req(1'b0, 3'b100, 32'h0000_0102, 32'd0, 32'h12A4_5678, 2);
    do_req(1'b0, 3'b001, 32'h0000_0102, 32'd0, 32'h8001_1234, 3);
    do_req(1'b0, 3'b101, 32'h0000_0100, 32'd0, 32'h1234_F00D, 1);
    do_req(1'b0, 3'b010, 32'h0000_0104, 32'd0, 32'hCAFE_BABE, 1);
    do_req(1'b0, 3'b011, 32'h0000_010C, 32'd0, 32'h7654_3210, 1);
    do_req(1'b1, 3'b000, 32'h0000_0301, 32'h1234_565A, 32'd0, 1);
    do_req(1'b1, 3'b010, 32'h0000_0308, 32'h89AB_CDEF, 32'd0, 2);
    do_req(1'b0, 3'b001, 32'h0000_0103, 32'd0, 32'd0, 1);
    do_req(1'b1, 3'b001, 32'h0000_0201, 32'h0000_1234, 32'd0, 1);
    do_req(1'b0, 3'b000, 32'h0000_0003, 32'd0, 32'h7F00_0000, 1);
    for (int i = 0; i < 8; i++) begin
      do_req(1'($urandom_range(0, 1)), 3'($urandom_range(0, 7)), $urandom,
             $urandom, $urandom, $urandom_range(1, 3));
    end

`ifdef LSU_TIMEOUT_EN
    do_req(1'b0, 3'b010, 32'h0000_0400, 32'd0, 32'h1234_5678, 0);
    do_req(1'b0, 3'b010, 32'h0000_0404, 32'd0, 32'h0BAD_F00D, TMO);
    do_req(1'b1, 3'b010, 32'h0000_0408, 32'h5555_AAAA, 32'd0, TMO + 3);
`else
    do_req(1'b0, 3'b010, 32'h0000_0400, 32'd0, 32'h1234_5678, 9);
`endif

    // Reset in the middle of a bus access: no response may appear.
    @(negedge clk); #1;
    slave_delay = 0;
    b.addr = 32'h0000_0500;
    b.wen = 1'b1;
    b.wdata = 32'h0F0F_0F0F;
    b.wstrb = 4'b1111;
    bus_q.push_back(b);
    req_wen = 1'b1;
    req_func3 = 3'b010;
    req_addr = 32'h0000_0500;
    req_wdata = 32'h0F0F_0F0F;
    req_valid = 1'b1;
    repeat (2) @(negedge clk);
    #1 rst_n = 1'b0;
    #1;
    chk("arst_dbus_valid", 32'(dbus_valid), 0);
    chk("arst_dbus_wen", 32'(dbus_wen), 0);
    chk("arst_dbus_addr", dbus_addr, 0);
    chk("arst_rsp_valid", 32'(rsp_valid), 0);
    req_valid = 1'b0;
    repeat (2) @(negedge clk);
    #1 rst_n = 1'b1;
    do_req(1'b0, 3'b010, 32'h0000_0504, 32'd0, 32'hA5A5_5A5A, 1);

    repeat (4) @(negedge clk);
    chk("rsp_q_empty", 32'(rsp_q.size()), 0);
    chk("bus_q_empty", 32'(bus_q.size()), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/load_store_unit.md
LOAD_STORE_UNIT -- requirements
Module: load_store_unit

Interface
REQ-001 SHALL have parameter TIMEOUT_CYCLES, default 255, the maximum number of BUS-state cycles spent waiting for dbus_ready; legal range 1..65535.
REQ-002 SHALL have port clk  input  1  the only clock; all state changes on its rising edge.
REQ-003 SHALL have port rst_n  input  1  asynchronous, active-low reset.
REQ-004 SHALL have port req_valid  input  1  core has a load/store pending; held stable while stall_o=1.
REQ-005 SHALL have port req_wen  input  1  1=store, 0=load.
REQ-006 SHALL have port req_func3  input  3  RV32I funct3 (size/sign).
REQ-007 SHALL have port req_addr  input  32  byte address.
REQ-008 SHALL have port req_wdata  input  32  unaligned store source (rs2).
REQ-009 SHALL have port stall_o  output  1  freeze core PC/regfile.
REQ-010 SHALL have port rsp_valid  output  1  one-cycle completion pulse.
REQ-011 SHALL have port rsp_rdata  output  32  aligned, extended load result.
REQ-012 SHALL have port err_misalign  output  1  completion was a misaligned access.
REQ-013 SHALL have port err_timeout  output  1  completion was a bus timeout.
REQ-014 SHALL have port dbus_valid  output  1  bus request.
REQ-015 SHALL have port dbus_wen  output  1  bus write.
REQ-016 SHALL have port dbus_addr  output  32  registered copy of req_addr.
REQ-017 SHALL have port dbus_wdata  output  32  lane-replicated store data.
REQ-018 SHALL have port dbus_wstrb  output  4  byte enables; 0000 for loads.
REQ-019 SHALL have port dbus_ready  input  1  slave accepts/returns data this cycle.
REQ-020 SHALL have port dbus_rdata  input  32  read word, valid when dbus_ready=1.

Function
REQ-021 SHALL implement FSM IDLE, BUS, RESP; IDLE->BUS on req_valid with aligned access; IDLE->RESP on req_valid with misaligned access; BUS->RESP on dbus_ready or timeout; RESP->IDLE unconditionally.
REQ-022 SHALL treat as misaligned: halfword (funct3 x01) with addr[0]=1; word (funct3 010, or any other non-byte code) with addr[1:0]!=00; byte never misaligned.
REQ-023 SHALL register addr, wen, funct3, wdata, wstrb on the IDLE->BUS edge; all dbus_* outputs are registers.
REQ-024 SHALL generate stores: SB wdata={4{b}}, wstrb=0001<<addr[1:0]; SH wdata={2{h}}, wstrb=addr[1]?1100:0011; other funct3 full word, 1111.
REQ-025 SHALL align loads: shift dbus_rdata right by 8*addr[1:0]; LB/LH sign-extend, LBU/LHU zero-extend, LW and undefined codes pass word unshifted; result captured on dbus_ready.
REQ-026 SHALL drive dbus_valid=1 for every BUS cycle and drop it the cycle after dbus_ready=1 is sampled.
REQ-027 SHALL drive stall_o = req_valid AND state!=RESP (combinational); RESP cycle releases core.
REQ-028 SHALL assert rsp_valid, and err_* where applicable, only in RESP, for exactly one cycle; rsp_rdata=0 on error or store.
REQ-029 SHALL ignore req_valid during BUS and RESP; a new request is accepted earliest the cycle after RESP.
REQ-030 SHALL complete an aligned access with dbus_ready=1 on the first BUS cycle in 3 cycles (IDLE accept, BUS, RESP).

Reset
REQ-031 SHALL on rst_n=0 immediately enter IDLE and force dbus_valid, dbus_wen, rsp_valid, err_misalign, err_timeout to 0, dbus_addr/dbus_wdata/rsp_rdata to 0, and dbus_wstrb to 0000, including mid-BUS; no RESP pulse for the aborted access.

Configuration
REQ-032 SHALL compile the bus watchdog only when macro LSU_TIMEOUT_EN is defined: a counter, cleared on entering BUS, that forces BUS->RESP with err_timeout=1 and dbus_valid dropped after TIMEOUT_CYCLES cycles without dbus_ready; dbus_ready in the final cycle wins over the timeout.
REQ-033 SHALL, without LSU_TIMEOUT_EN, wait in BUS indefinitely, tie err_timeout to 0 and omit the counter.

Verification
REQ-034 SHALL cover: LB addr 0x103, dbus_rdata 0x80FF_FFFF, ready first cycle -> rsp_rdata 0xFFFF_FF80, rsp_valid at cycle 3.
REQ-035 SHALL cover: SH addr 0x202, wdata 0x0000_ABCD -> dbus_wdata 0xABCD_ABCD, wstrb 1100, dbus_wen=1.
REQ-036 SHALL cover: LW addr 0x101 -> no dbus_valid, err_misalign pulse, rsp_rdata 0, stall released in RESP.
REQ-037 SHALL cover: LSU_TIMEOUT_EN, TIMEOUT_CYCLES=4, dbus_ready held 0 -> dbus_valid 4 cycles, err_timeout pulse; ready in the 4th cycle -> normal completion, no error.
REQ-038 SHALL cover: rst_n low during BUS with dbus_ready=0 -> dbus_valid 0 asynchronously, no rsp_valid, next request after release completes normally.
